// File: rtl/alu_seq_if.sv
// alu_seq_if
// Request/response bundle for the sequential execute-stage ALU.
//   in_valid / in_ready : request handshake (producer -> ALU)
//   op, in1, in2        : operation code and operands, qualified by in_valid
//   out_valid/out_ready : result handshake (ALU -> consumer)
//   out, err            : result and illegal-op flag, qualified by out_valid
// The master modport is the producer/consumer side; the slave modport is the ALU.
interface alu_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out;
    logic         err;

    modport master (
        output in_valid, op, in1, in2, out_ready,
        input  in_ready, out_valid, out, err
    );

    modport slave (
        input  in_valid, op, in1, in2, out_ready,
        output in_ready, out_valid, out, err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq
// Sequential integer ALU: single-cycle ADD/SUB/logic/shift/compare, plus
// iterative shift-add multiply (MUL/MULHU) and restoring divide (DIVU/REMU)
// taking N iterations. Results are held in DONE until the consumer takes them.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_seq_if slave (request and result handshakes)
module alu_seq #(
    parameter int N = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(N);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state;
    state_t         state_next;

    logic [3:0]     op_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   out_q;
    logic           err_q;

    logic           accept;
    logic           iterative;
    logic           div_zero;
    logic [SW-1:0]  shamt;
    logic [N-1:0]   quick_res;
    logic           quick_err;

    logic [N:0]     mul_sum;
    logic [2*N-1:0] mul_next;
    logic [N:0]     div_shift;
    logic [N-1:0]   div_diff;
    logic           div_ge;
    logic [2*N-1:0] div_next;
    logic [2*N-1:0] acc_next;
    logic [N-1:0]   iter_res;

    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.out_valid = (state == DONE);
    assign bus.out       = out_q;
    assign bus.err       = err_q;

    assign accept    = bus.in_valid && bus.in_ready;
    assign iterative = (bus.op >= 4'd10) && (bus.op <= 4'd13);
    assign div_zero  = ((bus.op == 4'd12) || (bus.op == 4'd13)) && (bus.in2 == '0);
    assign shamt     = bus.in2[SW-1:0];

    // Results that are ready straight from the request operands. Divide by
    // zero lands here too, since it never enters the iterative loop.
    always_comb begin
        quick_res = '0;
        quick_err = 1'b0;
        case (bus.op)
            4'd0:  quick_res = bus.in1 + bus.in2;
            4'd1:  quick_res = bus.in1 - bus.in2;
            4'd2:  quick_res = bus.in1 ^ bus.in2;
            4'd3:  quick_res = bus.in1 | bus.in2;
            4'd4:  quick_res = bus.in1 & bus.in2;
            4'd5:  quick_res = bus.in1 << shamt;
            4'd6:  quick_res = bus.in1 >> shamt;
            4'd7:  quick_res = N'($signed(bus.in1) >>> shamt);
            4'd8:  quick_res = {{(N-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
            4'd9:  quick_res = {{(N-1){1'b0}}, (bus.in1 < bus.in2)};
            4'd12: quick_res = '1;
            4'd13: quick_res = bus.in1;
            4'd10, 4'd11: quick_res = '0;
            default: begin
                quick_res = '0;
                quick_err = 1'b1;
            end
        endcase
    end

    // One iteration of either algorithm over the shared 2N-bit accumulator.
    // Multiply: acc = {partial high, remaining multiplier bits}, LSB first.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits},
    // MSB first; when the shifted remainder fits the divisor the subtraction
    // result fits in N bits, so the carry-out bit can be dropped.
    always_comb begin
        mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, acc[N-1:1]};
        div_shift = {acc[2*N-1:N], acc[N-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift[N-1:0] - b_q;
        div_next  = {(div_ge ? div_diff : div_shift[N-1:0]), acc[N-2:0], div_ge};
        acc_next  = (op_q[3:1] == 3'b101) ? mul_next : div_next;
        iter_res  = op_q[0] ? acc_next[2*N-1:N] : acc_next[N-1:0];
    end

    // Next-state logic: iterative ops spend N cycles in BUSY, leaving on the
    // iteration that brings the counter to zero.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (iterative && !div_zero) ? BUSY : DONE;
            BUSY:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Datapath registers: capture the request, step the iteration, and
    // register results. out/err are only written when entering DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= bus.op;
                        a_q  <= bus.in1;
                        b_q  <= bus.in2;
                        if (iterative && !div_zero) begin
                            cnt <= CW'(N);
                            acc <= (bus.op[3:1] == 3'b101) ? {{N{1'b0}}, bus.in2}
                                                           : {{N{1'b0}}, bus.in1};
                        end else begin
                            out_q <= quick_res;
                            err_q <= quick_err;
                        end
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        out_q <= iter_res;
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential, parameterised integer ALU for the execute stage, extending the single-cycle five-operation ALU with shifts, comparisons, iterative unsigned multiply, and iterative unsigned divide/remainder. Operands enter and results leave through valid/ready handshakes. Single-cycle operations return after one clock; MUL/DIV operations occupy the unit for N iterations. The pipeline stalls on `in_ready` while the unit is busy.

## Interface
- `N`, default 32: operand/result width; power of two, N >= 4.
- `clk`  input  1: clock; all state updates on rising edge.
- `rst_n`  input  1: synchronous reset, active-low.
- `in_valid`  input  1: operation request valid.
- `in_ready`  output  1: unit can accept a request this cycle.
- `op`  input  4: operation code (encoding below).
- `in1`  input  N: operand 1 (dividend / multiplicand).
- `in2`  input  N: operand 2 (divisor / multiplier / shift amount).
- `out_valid`  output  1: result valid.
- `out_ready`  input  1: consumer takes the result this cycle.
- `out`  output  N: result.
- `err`  output  1: qualified by `out_valid`; set for an illegal op.

## Operation
- Op encoding: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL (low N bits), 11 MULHU (high N bits, unsigned), 12 DIVU, 13 REMU. Codes 14–15 are illegal: `out` = 0, `err` = 1, 1-cycle path.
- Arithmetic wraps modulo 2^N. Shifts use `in2[$clog2(N)-1:0]`; the upper bits are ignored. SLT/SLTU return 0 or 1, zero-extended.
- FSM states: IDLE, BUSY, DONE. `in_ready` = (state == IDLE) && `rst_n`.
- IDLE, on `in_valid && in_ready`: latch `op`, `in1`, `in2`.
  - Ops 0–9, 14, 15: compute and register `out`, then go to DONE.
  - Ops 10–13: load the iteration counter with N, then go to BUSY.
- MUL/MULHU: shift-add over a 2N-bit product register, one multiplier bit per cycle, LSB first.
- DIVU/REMU: restoring division, one quotient bit per cycle, MSB first.
- BUSY: perform one iteration per cycle and decrement the counter. When the counter reaches 0, register the selected result and go to DONE.
- Divide by zero (ops 12–13 with `in2` == 0) short-circuits to DONE in 1 cycle. DIVU returns all ones; REMU returns `in1`. `err` stays 0.
- DONE: `out_valid` = 1. `out` and `err` are held stable until `out_ready`. On `out_ready`, go to IDLE.
- DONE does not accept a new request in the same cycle: `in_ready` is 0 in DONE.
- `out` is held at its last value outside DONE. Consumers must not sample `out` unless `out_valid` is 1.
- Reset (`rst_n` = 0 at a clock edge): state = IDLE, `out_valid` = 0, `out` = 0, `err` = 0, counter = 0. Reset has priority in every state. An in-flight BUSY operation is discarded and produces no result.

## Timing
- Accept at edge k (`in_valid && in_ready` sampled high).
- 1-cycle ops: `out_valid` is high from edge k+1.
- MUL/MULHU/DIVU/REMU: `out_valid` is high from edge k+N+1. For N = 32, that is 33 cycles after acceptance.
- Result leaves at the first edge in DONE with `out_ready` high. `in_ready` rises the following cycle.
- Peak throughput:
  - 1-cycle ops: 1 op every 2 cycles.
  - Iterative ops: 1 op every N+2 cycles.
- `out_valid` never deasserts without an `out_ready` handshake, except by reset.
- Inputs are ignored while `in_ready` = 0. The producer holds them under standard valid/ready rules.

## Test plan
- Reset and basic ops:
  - Hold `rst_n` = 0 for 2 cycles with `in_valid` = 1. Required: `in_ready` = 0, `out_valid` = 0, `out` = 0.
  - Release reset, then ADD 0xFFFFFFFF + 1. Required: `out` = 0x0 one cycle later.
  - SUB 0 − 1. Required: `out` = 0xFFFFFFFF.
- Shifts and compares:
  - SRA 0x80000000 by `in2` = 0x24 (uses 4). Required: `out` = 0xF8000000.
  - SLT 0xFFFFFFFF vs 1. Required: `out` = 1.
  - SLTU with the same operands. Required: `out` = 0.
- Multiply:
  - MUL 0xFFFFFFFF × 0xFFFFFFFF. Required: `out` = 0x00000001, `out_valid` exactly 33 cycles after accept.
  - MULHU with the same operands. Required: `out` = 0xFFFFFFFE.
  - `in_ready` = 0 throughout BUSY.
- Divide:
  - DIVU 100 / 7. Required: `out` = 14.
  - REMU 100 / 7. Required: `out` = 2.
  - DIVU 5 / 0. Required: `out` = 0xFFFFFFFF after 1 cycle.
  - REMU 5 / 0. Required: `out` = 5.
- Backpressure and illegal op:
  - Hold `out_ready` = 0 for 10 cycles after a result. Required: `out_valid` and `out` stable, `in_ready` = 0.
  - Issue op 15. Required: `out` = 0, `err` = 1.
- Reset mid-operation:
  - Assert `rst_n` = 0 at iteration 10 of a DIVU. Required: no `out_valid` is produced.
  - Next, ADD 2 + 3 after reset. Required: `out` = 5 with correct 1-cycle latency.
